// File: rtl/ir_nec_tx.sv
// NEC infrared frame envelope generator: serialises an address/command pair
// (or a repeat code) into a mark/space envelope timed in NEC units.
module ir_nec_tx #(
  parameter int unsigned UNIT_TICKS = 27000,
  parameter int unsigned GAP_UNITS  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic       tx_repeat,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  output logic       tx_ready,
  output logic       busy,
  output logic       dout
);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  localparam logic [31:0] TICK_MAX = 32'(UNIT_TICKS - 1);
  localparam logic [7:0]  GAP_LEN  = 8'(GAP_UNITS);

  state_t      state, state_nxt;
  logic [31:0] tick;
  logic [7:0]  unit;
  logic [5:0]  bit_idx;
  logic [31:0] data;
  logic        rep;
  logic [7:0]  seg_len;
  logic        unit_end, seg_end, accept, mark_nxt;

  assign accept   = (state == IDLE) && tx_valid && tx_ready;
  assign unit_end = (tick == TICK_MAX);
  assign seg_end  = unit_end && (unit == seg_len - 8'd1);

  always_comb begin
    seg_len = 8'd1;
    case (state)
      LEAD_MARK:  seg_len = 8'd16;
      LEAD_SPACE: seg_len = rep ? 8'd4 : 8'd8;
      BIT_SPACE:  seg_len = data[bit_idx[4:0]] ? 8'd3 : 8'd1;
      GAP:        seg_len = GAP_LEN;
      default:    seg_len = 8'd1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept)  state_nxt = LEAD_MARK;
      LEAD_MARK:  if (seg_end) state_nxt = LEAD_SPACE;
      LEAD_SPACE: if (seg_end) state_nxt = rep ? STOP_MARK : BIT_MARK;
      BIT_MARK:   if (seg_end) state_nxt = BIT_SPACE;
      BIT_SPACE:  if (seg_end) state_nxt = (bit_idx == 6'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (seg_end) state_nxt = GAP;
      GAP:        if (seg_end) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    mark_nxt = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) ||
               (state_nxt == STOP_MARK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      dout     <= 1'b0;
    end else begin
      tx_ready <= (state_nxt == IDLE);
      busy     <= (state_nxt != IDLE);
      dout     <= mark_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick    <= '0;
      unit    <= '0;
      bit_idx <= '0;
      data    <= '0;
      rep     <= 1'b0;
    end else if (accept) begin
      data    <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
      rep     <= tx_repeat;
      tick    <= '0;
      unit    <= '0;
      bit_idx <= '0;
    end else if (state != IDLE) begin
      if (seg_end) begin
        tick <= '0;
        unit <= '0;
        if (state == BIT_SPACE) bit_idx <= bit_idx + 6'd1;
      end else if (unit_end) begin
        tick <= '0;
        unit <= unit + 8'd1;
      end else begin
        tick <= tick + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed bench for ir_nec_tx: decodes the dout envelope into run lengths
// and bits, and checks timing, reset abort and back-to-back spacing.
module tb_ir_nec_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0, tx_repeat = 1'b0;
  logic [7:0] tx_addr = 8'h00, tx_cmd = 8'h00;
  logic       tx_ready, busy, dout;
  logic       valid1 = 1'b0;
  logic       ready1, busy1, dout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ir_nec_tx #(.UNIT_TICKS(4), .GAP_UNITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_repeat(tx_repeat),
    .tx_addr(tx_addr), .tx_cmd(tx_cmd), .tx_ready(tx_ready), .busy(busy),
    .dout(dout));

  ir_nec_tx #(.UNIT_TICKS(1), .GAP_UNITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid1), .tx_repeat(1'b0),
    .tx_addr(8'h00), .tx_cmd(8'hFF), .tx_ready(ready1), .busy(busy1),
    .dout(dout1));

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  cmd;
    logic        rep;
    logic        inject;
    logic [31:0] exp_word;
    int          exp_space;
    int          exp_busy;
  } vec_t;

  vec_t vecs[5];
  bit   smp[2048];
  bit   s1[300];
  int   nsmp, nbusy;
  int   runs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rl(input int i);
    return (i < runs.size()) ? runs[i] : -1;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  // Accept one request, then record dout every cycle until tx_ready returns.
  task automatic send(input vec_t v, input string name);
    wait_ready(name);
    tx_valid = 1'b1; tx_repeat = v.rep; tx_addr = v.addr; tx_cmd = v.cmd;
    @(posedge clk);
    nsmp = 0; nbusy = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tx_valid = 1'b0; tx_repeat = ~v.rep; tx_addr = ~v.addr; tx_cmd = v.cmd ^ 8'h5A;
      end
      if (v.inject && k == 70) begin
        tx_valid = 1'b1; tx_repeat = 1'b1; tx_addr = 8'h77; tx_cmd = 8'h88;
      end
      if (v.inject && k == 71) tx_valid = 1'b0;
      if (tx_ready) break;
      smp[nsmp] = dout;
      nsmp++;
      if (busy) nbusy++;
    end
  endtask

  task automatic check_frame(input vec_t v, input string name);
    int len, stop_i, bad;
    bit cur;
    logic [31:0] word;
    runs.delete();
    cur = smp[0]; len = 0;
    for (int i = 0; i < nsmp; i++) begin
      if (smp[i] == cur) len++;
      else begin runs.push_back(len); cur = smp[i]; len = 1; end
    end
    runs.push_back(len);
    stop_i = v.rep ? 2 : 66;
    chk({name, "_first_mark"}, smp[0], 1);
    chk({name, "_lead_mark"}, rl(0), 64);
    chk({name, "_lead_space"}, rl(1), v.exp_space);
    chk({name, "_nruns"}, runs.size(), stop_i + 2);
    if (!v.rep) begin
      word = '0; bad = 0;
      for (int b = 0; b < 32; b++) begin
        if (rl(2 + 2*b) != 4) bad++;
        if (rl(3 + 2*b) == 12) word[b] = 1'b1;
        else if (rl(3 + 2*b) != 4) bad++;
      end
      chk({name, "_word"}, word, v.exp_word);
      chk({name, "_bit_timing_bad"}, bad, 0);
    end
    chk({name, "_stop_mark"}, rl(stop_i), 4);
    chk({name, "_gap"}, rl(stop_i + 1), 32);
    chk({name, "_busy_cycles"}, nbusy, v.exp_busy);
    repeat (8) @(negedge clk);
    chk({name, "_idle_after"}, {busy, dout, tx_ready}, 3'b001);
  endtask

  initial begin
    int r0, lows, lead, rises;
    bit prev;
    vecs[0] = '{8'h00, 8'hFF, 1'b0, 1'b0, 32'h00FFFF00, 32, 516};
    vecs[1] = '{8'h01, 8'h00, 1'b0, 1'b0, 32'hFF00FE01, 32, 516};
    vecs[2] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 32'hC33C5AA5, 32, 516};
    vecs[3] = '{8'h12, 8'h34, 1'b1, 1'b0, 32'h0,        16, 116};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 1'b0, 32'hCB34ED12, 32, 516};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {dout, busy, tx_ready}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", tx_ready, 1);

    // UNIT_TICKS=1 with tx_valid held: frames 121 cycles, 9 low cycles between.
    valid1 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      s1[k] = dout1;
    end
    valid1 = 1'b0;
    r0 = 0;
    while (r0 < 100 && !s1[r0]) r0++;
    lead = 0;
    for (int k = r0; k < r0 + 20; k++) if (s1[k] && lead == k - r0) lead++;
    chk("u1_lead_mark", lead, 16);
    chk("u1_last_bit_space", s1[r0 + 119], 0);
    chk("u1_stop_mark", s1[r0 + 120], 1);
    lows = 0;
    for (int k = r0 + 121; k < r0 + 130; k++) if (!s1[k]) lows++;
    chk("u1_gap_low", lows, 9);
    chk("u1_next_frame", s1[r0 + 130], 1);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i], $sformatf("v%0d", i));
      check_frame(vecs[i], $sformatf("v%0d", i));
    end

    // Reset during bit 10 mark (12th rising edge of dout).
    wait_ready("rst");
    tx_valid = 1'b1; tx_repeat = 1'b0; tx_addr = 8'h00; tx_cmd = 8'hFF;
    @(posedge clk);
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 1000 && rises < 12; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (dout && !prev) rises++;
      prev = dout;
    end
    chk("rst_reached_bit10", rises, 12);
    #2 rst_n = 1'b0;
    #1 chk("rst_abort_outputs", {dout, busy, tx_ready}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_first_edge", tx_ready, 1);
    send(vecs[4], "post_rst");
    check_frame(vecs[4], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_nec_tx.md
IR_NEC_TX -- requirements
Module: ir_nec_tx

Interface
REQ-001 SHALL have parameter UNIT_TICKS, default 27000, clock cycles per 562.5 us NEC time unit (legal 1..2^31-1).
REQ-002 SHALL have parameter GAP_UNITS, default 64, minimum idle units enforced after each frame (legal 1..255).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_valid  input  1  request to send a frame.
REQ-006 SHALL have port tx_repeat  input  1  sampled with tx_valid; 1 = send NEC repeat code, ignore addr/cmd.
REQ-007 SHALL have port tx_addr  input  8  NEC address byte.
REQ-008 SHALL have port tx_cmd  input  8  NEC command byte.
REQ-009 SHALL have port tx_ready  output  1  high only in IDLE; request accepted when tx_valid and tx_ready are both high on a clock edge.
REQ-010 SHALL have port busy  output  1  high in every state other than IDLE, including GAP.
REQ-011 SHALL have port dout  output  1  registered envelope, 1 = mark (carrier on), 0 = space; drives the din input of the downstream carrier modulator.

Function
REQ-012 States SHALL be IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
REQ-013 A tick counter SHALL count 0..UNIT_TICKS-1 and wrap; a unit counter SHALL count completed units within the current state; a segment of N units SHALL last exactly N*UNIT_TICKS cycles.
REQ-014 On acceptance: latch data word {~cmd, cmd, ~addr, addr}, clear counters, latch tx_repeat, enter LEAD_MARK; dout SHALL be 1 starting the cycle after the accepting edge.
REQ-015 LEAD_MARK SHALL last 16 units with dout=1, then enter LEAD_SPACE.
REQ-016 LEAD_SPACE SHALL last 8 units (normal frame) or 4 units (repeat code) with dout=0; then BIT_MARK for normal frames, STOP_MARK for repeat codes.
REQ-017 Bits SHALL be sent LSB first from the 32-bit latched word, bit index 0..31 held in a 6-bit counter.
REQ-018 BIT_MARK SHALL last 1 unit with dout=1; BIT_SPACE SHALL last 1 unit for bit 0, 3 units for bit 1, with dout=0.
REQ-019 After BIT_SPACE of bit 31 the block SHALL enter STOP_MARK; otherwise advance bit index and return to BIT_MARK.
REQ-020 STOP_MARK SHALL last 1 unit with dout=1, then enter GAP.
REQ-021 GAP SHALL last GAP_UNITS units with dout=0, then enter IDLE and assert tx_ready.
REQ-022 tx_valid while busy SHALL be ignored, not queued; input changes after acceptance SHALL not affect the frame in flight.
REQ-023 Normal frame mark/space length SHALL be (16+8+sum over bits of (2 or 4)+1) units; repeat code length SHALL be 21 units; GAP SHALL follow both.
REQ-024 With UNIT_TICKS=1 every unit SHALL be one cycle with no dropped or extra cycles.
REQ-025 Back-to-back requests SHALL be possible: tx_valid held high SHALL be accepted on the first IDLE cycle after GAP.

Reset
REQ-026 While rst_n=0, dout=0, tx_ready=0, busy=0, state=IDLE, all counters and data register=0, asynchronously.
REQ-027 After rst_n deasserts, tx_ready SHALL be 1 at the first clock edge; reset mid-frame SHALL drop dout to 0 immediately and abort the frame, with no GAP enforced.

Verification (UNIT_TICKS=4, GAP_UNITS=8)
REQ-028 addr=0x00, cmd=0xFF, repeat=0 -> dout high 64 cycles, low 32, then 32 bit pairs, stop mark 4 cycles; frame 121 units = 484 cycles; then 32 cycles low; tx_ready returns at cycle 516.
REQ-029 addr=0x01, cmd=0x00 -> first bit space 12 cycles (bit 1), second bit space 4 cycles; bits 8..15 (~addr=0xFE) give spaces 4 then 12 x7.
REQ-030 tx_repeat=1 -> mark 64 cycles, space 16, mark 4, gap 32; busy high 116 cycles total.
REQ-031 Pulse tx_valid during LEAD_SPACE with different data -> frame unchanged, no second frame sent.
REQ-032 Assert rst_n=0 during bit 10 mark -> dout=0 same time, busy=0; after release a new request sends a full, correct frame.
REQ-033 UNIT_TICKS=1, tx_valid held high -> consecutive frames separated by exactly GAP_UNITS low cycles plus 1 IDLE cycle.
